// File: rtl/sb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sb_pkg
// Description : Shared types and fixed-point constants for the simulated
//               bifurcation iteration controller.
// Revision    : 1.0 - initial release
// ============================================================================
package sb_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MOM_ISSUE = 3'd1,
    ST_MOM_WAIT  = 3'd2,
    ST_POS_ISSUE = 3'd3,
    ST_POS_WAIT  = 3'd4,
    ST_FINISH    = 3'd5
  } sb_state_e;

  localparam int unsigned FRAC_WIDTH_DEFAULT = 16;

  // 1.0 in Q(frac_w) fixed point
  function automatic logic [63:0] sb_one(input int unsigned frac_w);
    sb_one = 64'd1 << frac_w;
  endfunction

  // 1.0 for the default fractional width
  localparam logic [63:0] ONE = 64'd1 << FRAC_WIDTH_DEFAULT;

endpackage
`default_nettype wire

// File: rtl/sb_pump_ramp.sv
`default_nettype none
// ============================================================================
// Module      : sb_pump_ramp
// Description : Saturating pump-amplitude accumulator. Cleared on a new run,
//               advanced by a_step on every completed iteration, clamped at
//               1.0 so the ramp can never wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_pump_ramp
  import sb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] a_step,
  output logic [DATA_WIDTH-1:0] pump_a
);

  localparam logic [DATA_WIDTH-1:0] C_ONE = DATA_WIDTH'(sb_one(FRAC_WIDTH));

  logic [DATA_WIDTH-1:0] pump_q;
  logic [DATA_WIDTH-1:0] pump_d;
  logic [DATA_WIDTH:0]   w_sum;

  // Next amplitude: one extra bit on the sum so a carry-out clamps instead of wrapping
  always_comb begin
    w_sum  = {1'b0, pump_q} + {1'b0, a_step};
    pump_d = pump_q;
    if (clr) begin
      pump_d = '0;
    end else if (step) begin
      pump_d = (w_sum > {1'b0, C_ONE}) ? C_ONE : w_sum[DATA_WIDTH-1:0];
    end
  end

  // Amplitude register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pump_q <= '0;
    end else begin
      pump_q <= pump_d;
    end
  end

  assign pump_a = pump_q;

endmodule
`default_nettype wire

// File: rtl/sb_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sb_iter_ctrl
// Description : Iteration sequencer for a simulated-bifurcation solver. Each
//               iteration launches the momentum update, then the position
//               update, ramps the pump amplitude, and counts completions.
//               A watchdog aborts a stalled datapath handshake.
//               Optional build macro SB_EARLY_STOP_EN adds early termination
//               once the sign vector of x has stopped changing.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_iter_ctrl
  import sb_pkg::*;
#(
  parameter int N            = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int FRAC_WIDTH   = 16,
  parameter int ITER_WIDTH   = 16,
  parameter int WDOG_CYCLES  = 255,
  parameter int STABLE_ITERS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ITER_WIDTH-1:0] num_iter,
  input  logic [DATA_WIDTH-1:0] a_step,
  output logic                  mom_go,
  input  logic                  mom_done,
  output logic                  pos_go,
  input  logic                  pos_done,
  input  logic [N-1:0]          x_sign,
  output logic [DATA_WIDTH-1:0] pump_a,
  output logic [ITER_WIDTH-1:0] iter_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  early_stop
);

  localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WDOG_W-1:0] C_WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  sb_state_e             state_q, state_d;
  logic [ITER_WIDTH-1:0] num_iter_q, num_iter_d;
  logic [DATA_WIDTH-1:0] a_step_q, a_step_d;
  logic [ITER_WIDTH-1:0] iter_cnt_q, iter_cnt_d;
  logic [WDOG_W-1:0]     wdog_q, wdog_d;
  logic                  error_q, error_d;

  logic                  w_start_acc;
  logic                  w_pos_acc;
  logic                  w_es_hit;
  logic [ITER_WIDTH-1:0] w_iter_next;

  assign w_start_acc = (state_q == ST_IDLE) && start;
  assign w_pos_acc   = (state_q == ST_POS_WAIT) && pos_done;
  assign w_iter_next = iter_cnt_q + ITER_WIDTH'(1);

  // Sequencer: next state, latched run parameters, iteration count and watchdog
  always_comb begin
    state_d    = state_q;
    num_iter_d = num_iter_q;
    a_step_d   = a_step_q;
    iter_cnt_d = iter_cnt_q;
    wdog_d     = wdog_q;
    error_d    = error_q;

    case (state_q)
      ST_IDLE: begin
        if (w_start_acc) begin
          num_iter_d = num_iter;
          a_step_d   = a_step;
          iter_cnt_d = '0;
          wdog_d     = '0;
          error_d    = 1'b0;
          state_d    = (num_iter == '0) ? ST_FINISH : ST_MOM_ISSUE;
        end
      end
      ST_MOM_ISSUE: begin
        wdog_d  = '0;
        state_d = ST_MOM_WAIT;
      end
      ST_MOM_WAIT: begin
        // A done in the final watchdog cycle still wins over the timeout
        if (mom_done) begin
          state_d = ST_POS_ISSUE;
        end else if (wdog_q == C_WDOG_LAST) begin
          error_d = 1'b1;
          state_d = ST_FINISH;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      ST_POS_ISSUE: begin
        wdog_d  = '0;
        state_d = ST_POS_WAIT;
      end
      ST_POS_WAIT: begin
        if (w_pos_acc) begin
          iter_cnt_d = w_iter_next;
          state_d    = ((w_iter_next == num_iter_q) || w_es_hit) ? ST_FINISH : ST_MOM_ISSUE;
        end else if (wdog_q == C_WDOG_LAST) begin
          error_d = 1'b1;
          state_d = ST_FINISH;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      num_iter_q <= '0;
      a_step_q   <= '0;
      iter_cnt_q <= '0;
      wdog_q     <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_iter_q <= num_iter_d;
      a_step_q   <= a_step_d;
      iter_cnt_q <= iter_cnt_d;
      wdog_q     <= wdog_d;
      error_q    <= error_d;
    end
  end

`ifdef SB_EARLY_STOP_EN
  localparam int STB_W = $clog2(STABLE_ITERS + 1);

  logic [N-1:0]     sign_prev_q, sign_prev_d;
  logic [STB_W-1:0] stable_q, stable_d;
  logic             early_stop_q, early_stop_d;

  // Stability tracker: run length of iterations whose sign vector repeated
  always_comb begin
    sign_prev_d  = sign_prev_q;
    stable_d     = stable_q;
    early_stop_d = early_stop_q;
    w_es_hit     = 1'b0;
    if (w_start_acc) begin
      sign_prev_d  = '0;
      stable_d     = '0;
      early_stop_d = 1'b0;
    end else if (w_pos_acc) begin
      sign_prev_d = x_sign;
      // No previous vector exists on the first iteration, so it counts as a change
      if ((iter_cnt_q != '0) && (x_sign == sign_prev_q)) begin
        stable_d = stable_q + STB_W'(1);
        if (stable_d == STB_W'(STABLE_ITERS)) begin
          w_es_hit     = 1'b1;
          early_stop_d = 1'b1;
        end
      end else begin
        stable_d = '0;
      end
    end
  end

  // Stability tracker registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_prev_q  <= '0;
      stable_q     <= '0;
      early_stop_q <= 1'b0;
    end else begin
      sign_prev_q  <= sign_prev_d;
      stable_q     <= stable_d;
      early_stop_q <= early_stop_d;
    end
  end

  assign early_stop = early_stop_q;
`else
  logic w_unused_x_sign;

  assign w_es_hit        = 1'b0;
  assign early_stop      = 1'b0;
  assign w_unused_x_sign = ^x_sign;
`endif

  sb_pump_ramp #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_pump_ramp (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (w_start_acc),
    .step   (w_pos_acc),
    .a_step (a_step_q),
    .pump_a (pump_a)
  );

  assign mom_go   = (state_q == ST_MOM_ISSUE);
  assign pos_go   = (state_q == ST_POS_ISSUE);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_FINISH);
  assign error    = error_q;
  assign iter_cnt = iter_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sb_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sb_iter_ctrl
// Description : Self-checking bench for sb_iter_ctrl with latency-programmable
//               datapath stubs, a vector table, random runs against a
//               closed-form model, and watchdog/reset corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sb_iter_ctrl;

  localparam int N      = 8;
  localparam int DW     = 32;
  localparam int FW     = 16;
  localparam int IW     = 16;
  localparam int WDOG   = 255;
  localparam int STABLE = 4;
  localparam longint ONE = 64'h10000;

`ifdef SB_EARLY_STOP_EN
  localparam bit ES_EN = 1'b1;
`else
  localparam bit ES_EN = 1'b0;
`endif

  typedef struct {
    int     n;
    longint s;
    int     mlat;
    int     plat;
    bit     sconst;
    bit     poke;
    bit     mhold;
    bit     phold;
    int     lat;
    int     iter;
    longint pump;
    bit     err;
    bit     es;
    int     mgo;
    int     pgo;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [IW-1:0] num_iter = '0;
  logic [DW-1:0] a_step = '0;
  logic          mom_go, pos_go, mom_done, pos_done;
  logic [N-1:0]  x_sign = '0;
  logic [DW-1:0] pump_a;
  logic [IW-1:0] iter_cnt;
  logic          busy, done, error, early_stop;

  int n_cmp = 0;
  int n_fail = 0;

  // Datapath stub controls
  int mom_lat = 1, pos_lat = 1;
  bit mom_hold = 1'b0, pos_hold = 1'b0, inj_mom = 1'b0, inj_pos = 1'b0;
  int mom_cnt = 0, pos_cnt = 0;

  sb_iter_ctrl #(
    .N(N), .DATA_WIDTH(DW), .FRAC_WIDTH(FW), .ITER_WIDTH(IW),
    .WDOG_CYCLES(WDOG), .STABLE_ITERS(STABLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_iter(num_iter), .a_step(a_step),
    .mom_go(mom_go), .mom_done(mom_done), .pos_go(pos_go), .pos_done(pos_done),
    .x_sign(x_sign), .pump_a(pump_a), .iter_cnt(iter_cnt), .busy(busy),
    .done(done), .error(error), .early_stop(early_stop)
  );

  always #5 clk = ~clk;

  // Datapath stubs: valid returns mom_lat/pos_lat cycles after the go pulse
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mom_cnt <= 0;
      pos_cnt <= 0;
    end else begin
      if (mom_go) mom_cnt <= mom_lat;
      else if (mom_cnt != 0) mom_cnt <= mom_cnt - 1;
      if (pos_go) pos_cnt <= pos_lat;
      else if (pos_cnt != 0) pos_cnt <= pos_cnt - 1;
    end
  end

  assign mom_done = ((mom_cnt == 1) && !mom_hold) || inj_mom;
  assign pos_done = ((pos_cnt == 1) && !pos_hold) || inj_pos;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint sat(input longint k, input longint s);
    longint p;
    p = k * s;
    return (p > ONE) ? ONE : p;
  endfunction

  // Reference: each iteration costs issue + wait(mlat) + issue + wait(plat)
  function automatic vec_t model(input int n, input longint s, input int ml, input int pl,
                                 input bit sc, input bit pk);
    vec_t v;
    int eff;
    v.n = n; v.s = s; v.mlat = ml; v.plat = pl; v.sconst = sc; v.poke = pk;
    v.mhold = 1'b0; v.phold = 1'b0; v.err = 1'b0; v.es = 1'b0;
    eff = n;
    if (ES_EN && sc && (n >= STABLE + 1)) begin
      eff  = STABLE + 1;
      v.es = 1'b1;
    end
    v.lat  = (eff == 0) ? 1 : eff * (2 + ml + pl) + 1;
    v.iter = eff;
    v.pump = sat(eff, s);
    v.mgo  = eff;
    v.pgo  = eff;
    return v;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, ".pump"},  longint'(pump_a), 0);
    chk({tag, ".iter"},  longint'(iter_cnt), 0);
    chk({tag, ".busy"},  longint'(busy), 0);
    chk({tag, ".done"},  longint'(done), 0);
    chk({tag, ".err"},   longint'(error), 0);
    chk({tag, ".es"},    longint'(early_stop), 0);
    chk({tag, ".mgo"},   longint'(mom_go), 0);
    chk({tag, ".pgo"},   longint'(pos_go), 0);
  endtask

  task automatic run_case(input vec_t v, input string tag);
    int     c, mgo, pgo;
    longint prev_it;
    bit     seen;
    mom_lat = v.mlat; pos_lat = v.plat; mom_hold = v.mhold; pos_hold = v.phold;
    mgo = 0; pgo = 0; prev_it = 0; seen = 1'b0;
    x_sign = v.sconst ? N'(8'hA5) : N'(5);
    @(negedge clk);
    start = 1'b1; num_iter = IW'(v.n); a_step = DW'(v.s);
    @(negedge clk);
    start = 1'b0; num_iter = IW'(v.n + 3); a_step = ~a_step;
    c = 1;
    while (c <= 3000) begin
      inj_mom = 1'b0; inj_pos = 1'b0;
      if (c == 4) start = 1'b0;
      if (mom_go) mgo++;
      if (pos_go) pgo++;
      if (!v.sconst) x_sign = N'(pgo * 37 + 5);
      if (c == 1) begin
        chk({tag, ".c1_iter"}, longint'(iter_cnt), 0);
        chk({tag, ".c1_pump"}, longint'(pump_a), 0);
        chk({tag, ".c1_err"},  longint'(error), 0);
        chk({tag, ".c1_busy"}, longint'(busy), 1);
      end
      if (longint'(iter_cnt) != prev_it) begin
        chk({tag, ".iter_step"}, longint'(iter_cnt), prev_it + 1);
        chk({tag, ".pump_seq"},  longint'(pump_a), sat(longint'(iter_cnt), v.s));
        prev_it = longint'(iter_cnt);
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (v.n >= 1) begin
        if (c == 2) inj_pos = 1'b1;
        if (c == 3 && v.poke) begin
          start = 1'b1; num_iter = IW'(7);
        end
        if (c == 3 + v.mlat && !v.mhold) inj_mom = 1'b1;
      end
      @(negedge clk);
      c++;
    end
    inj_mom = 1'b0; inj_pos = 1'b0; start = 1'b0;
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("FAIL %s.timeout: no done within %0d cycles, expected at %0d", tag, c - 1, v.lat);
    end
    chk({tag, ".lat"},  c, v.lat);
    chk({tag, ".iter"}, longint'(iter_cnt), v.iter);
    chk({tag, ".pump"}, longint'(pump_a), v.pump);
    chk({tag, ".err"},  longint'(error), v.err);
    chk({tag, ".es"},   longint'(early_stop), v.es);
    chk({tag, ".busy"}, longint'(busy), 1);
    chk({tag, ".nmgo"}, mgo, v.mgo);
    chk({tag, ".npgo"}, pgo, v.pgo);
    @(negedge clk);
    chk({tag, ".idle_busy"}, longint'(busy), 0);
    chk({tag, ".idle_done"}, longint'(done), 0);
    chk({tag, ".hold_iter"}, longint'(iter_cnt), v.iter);
    chk({tag, ".hold_pump"}, longint'(pump_a), v.pump);
    chk({tag, ".hold_err"},  longint'(error), v.err);
    mom_hold = 1'b0; pos_hold = 1'b0;
  endtask

  vec_t tbl[8];

  initial begin
    vec_t v;
    //         n  s               ml  pl sc pk mh ph lat iter pump         err es mgo pgo
    tbl[0] = '{3, 64'h4000,       1,  1, 0, 0, 0, 0, 13, 3,  64'hC000,     0, 0, 3,  3};
    tbl[1] = '{0, 64'h1234,       1,  1, 0, 0, 0, 0, 1,  0,  64'h0,        0, 0, 0,  0};
    tbl[2] = '{5, 64'h8000,       1,  1, 0, 1, 0, 0, 21, 5,  64'h10000,    0, 0, 5,  5};
    tbl[3] = '{2, 64'h10,         3,  2, 0, 1, 0, 0, 15, 2,  64'h20,       0, 0, 2,  2};
    tbl[4] = '{1, 64'hFFFFFFFF,   1,  1, 0, 0, 0, 0, 5,  1,  64'h10000,    0, 0, 1,  1};
    tbl[5] = '{4, 64'h5555,       2,  1, 0, 0, 0, 0, 21, 4,  64'h10000,    0, 0, 4,  4};
    tbl[6] = '{1, 64'h10000,      1,  4, 0, 0, 0, 0, 8,  1,  64'h10000,    0, 0, 1,  1};
    tbl[7] = '{3, 64'h0,          1,  1, 0, 1, 0, 0, 13, 3,  64'h0,        0, 0, 3,  3};

    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("rst");
    rst_n = 1'b1;

    // Stray valids while idle must not start anything
    @(negedge clk);
    inj_mom = 1'b1; inj_pos = 1'b1;
    @(negedge clk);
    inj_mom = 1'b0; inj_pos = 1'b0;
    @(negedge clk);
    chk("idle_stray.busy", longint'(busy), 0);
    chk("idle_stray.iter", longint'(iter_cnt), 0);

    for (int i = 0; i < 8; i++) run_case(tbl[i], $sformatf("tbl%0d", i));

    // Watchdog: momentum valid withheld, position valid withheld
    v = '{2, 64'h100, 1, 1, 0, 0, 1, 0, 2 + WDOG, 0, 64'h0, 1, 0, 1, 0};
    run_case(v, "wdog_mom");
    v = '{2, 64'h100, 1, 1, 0, 0, 0, 1, 4 + WDOG, 0, 64'h0, 1, 0, 1, 1};
    run_case(v, "wdog_pos");
    // Valid arriving in the last permitted wait cycle is accepted
    v = model(1, 64'h300, WDOG, 1, 1'b0, 1'b0);
    run_case(v, "wdog_edge");

    // Constant sign vector over a long run
    v = model(100, 64'h1000, 1, 1, 1'b1, 1'b0);
    run_case(v, "const_sign");

    // Asynchronous reset during POS_WAIT of iteration 2
    mom_lat = 1; pos_lat = 3;
    @(negedge clk);
    start = 1'b1; num_iter = IW'(4); a_step = DW'(32'h4000);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("midrst.pre_iter", longint'(iter_cnt), 1);
    chk("midrst.pre_pump", longint'(pump_a), 64'h4000);
    chk("midrst.pre_busy", longint'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    v = model(3, 64'h4000, 1, 1, 1'b0, 1'b0);
    run_case(v, "post_rst");

    // Random runs against the closed-form model
    for (int i = 0; i < 12; i++) begin
      int     rn, rml, rpl;
      longint rs;
      bit     rsc, rpk;
      rn  = int'($urandom_range(0, 9));
      rs  = ($urandom_range(0, 1) == 1) ? longint'($urandom) : longint'($urandom_range(0, 32'h6000));
      rml = int'($urandom_range(1, 4));
      rpl = int'($urandom_range(1, 4));
      rsc = 1'($urandom_range(0, 1));
      rpk = 1'($urandom_range(0, 1));
      v = model(rn, rs, rml, rpl, rsc, rpk);
      run_case(v, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire

// File: doc/sb_iter_ctrl.md
SB_ITER_CTRL -- requirements
Module: sb_iter_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, number of oscillators.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, fixed-point word width.
REQ-003 SHALL have parameter FRAC_WIDTH, default 16, fractional bits.
REQ-004 SHALL have parameter ITER_WIDTH, default 16, iteration counter width.
REQ-005 SHALL have parameter WDOG_CYCLES, default 255, maximum wait for a datapath valid.
REQ-006 SHALL have parameter STABLE_ITERS, default 4, consecutive unchanged sign vectors for early stop.
REQ-007 clk  input  1  clock; all logic on rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 start  input  1  run request, sampled in IDLE only.
REQ-010 num_iter  input  ITER_WIDTH  iterations to run, latched on accepted start.
REQ-011 a_step  input  DATA_WIDTH  unsigned pump increment per iteration, latched on accepted start.
REQ-012 mom_go  output  1  one-cycle pulse launching the momentum (y) update.
REQ-013 mom_done  input  1  valid returned by the momentum update.
REQ-014 pos_go  output  1  one-cycle pulse launching the position update x_next = x + dt*y.
REQ-015 pos_done  input  1  valid returned by the position update.
REQ-016 x_sign  input  N  sign bits of x_next, valid with pos_done.
REQ-017 pump_a  output  DATA_WIDTH  current pump amplitude a(t), Q(FRAC_WIDTH).
REQ-018 iter_cnt  output  ITER_WIDTH  completed iterations.
REQ-019 busy, done, error, early_stop  output  1 each  status: running; one-cycle completion pulse; watchdog fault; early termination.

Function
REQ-020 SHALL implement states IDLE, MOM_ISSUE, MOM_WAIT, POS_ISSUE, POS_WAIT, FINISH.
REQ-021 IDLE+start: latch num_iter and a_step, clear iter_cnt and pump_a, go MOM_ISSUE; if num_iter==0 go FINISH without issuing any go pulse.
REQ-022 MOM_ISSUE: assert mom_go for exactly one cycle, go MOM_WAIT.
REQ-023 MOM_WAIT: on mom_done go POS_ISSUE; mom_done arriving in the cycle immediately after mom_go (1-cycle datapath latency) SHALL be accepted.
REQ-024 POS_ISSUE: assert pos_go for exactly one cycle, go POS_WAIT.
REQ-025 POS_WAIT on pos_done: iter_cnt+1; pump_a += a_step, saturating at 1.0 (1<<FRAC_WIDTH); go FINISH if iter_cnt+1==num_iter, else MOM_ISSUE.
REQ-026 Per-iteration latency with 1-cycle datapaths SHALL be 4 cycles (MOM_ISSUE, MOM_WAIT, POS_ISSUE, POS_WAIT).
REQ-027 Watchdog: in MOM_WAIT/POS_WAIT, count cycles; on reaching WDOG_CYCLES without done, set error (sticky until next accepted start) and go FINISH.
REQ-028 FINISH: pulse done one cycle, go IDLE; iter_cnt and pump_a SHALL hold their final values until next accepted start.
REQ-029 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored.
REQ-030 mom_done/pos_done outside their wait state SHALL be ignored.
REQ-031 pump_a addition SHALL use DATA_WIDTH+1 bits internally so overflow saturates rather than wraps.

Reset
REQ-032 Asserting rst_n low SHALL, at any time including mid-run, force state IDLE and all outputs to 0 (pump_a, iter_cnt, busy, done, error, early_stop, mom_go, pos_go), and clear latched inputs and the watchdog and stable counters.

Configuration
REQ-033 With SB_EARLY_STOP_EN defined: on each accepted pos_done compare x_sign with previous iteration's value (the first iteration always counts as changed); count consecutive equal results; when the count reaches STABLE_ITERS, set early_stop (held until next accepted start) and go FINISH even if iter_cnt<num_iter.
REQ-034 Without SB_EARLY_STOP_EN: x_sign SHALL be ignored, early_stop SHALL be constant 0, no sign register or stable counter SHALL be synthesized; port list is identical in both builds.

Structure
REQ-035 A shared package sb_pkg SHALL hold the state enum type and the fixed-point constant ONE = 1<<FRAC_WIDTH.
REQ-036 One sub-module, sb_pump_ramp (saturating pump accumulator), is natural; FSM, counters and watchdog stay in sb_iter_ctrl.

Verification
REQ-037 num_iter=3, a_step=0x4000, 1-cycle datapath stubs -> 3 mom_go and 3 pos_go pulses, done 13 cycles after start, iter_cnt=3, pump_a=0xC000.
REQ-038 num_iter=0 -> no go pulses, done one cycle after start, iter_cnt=0.
REQ-039 a_step=0x8000, num_iter=5 -> pump_a sequence 0x8000, 0x10000, then held at 0x10000.
REQ-040 pos_done withheld -> error=1 and done after WDOG_CYCLES wait cycles; next start clears error.
REQ-041 rst_n low during POS_WAIT of iteration 2 -> all outputs 0 immediately; subsequent start runs normally.
REQ-042 SB_EARLY_STOP_EN, STABLE_ITERS=4, num_iter=100, constant x_sign=0xA5 -> early_stop=1, done after iteration 5, iter_cnt=5.
